// File: rtl/multicycle_datapath.sv
// Four-state (FETCH/EXEC/MEM/WB) multicycle datapath with register file, ALU, flags and PC.
// Optional memory-access timeout with sticky mem_err is enabled by defining DATAPATH_MEM_TIMEOUT_EN.
module multicycle_datapath #(
  parameter int WIDTH       = 16,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] instr_addr,
  input  logic [WIDTH-1:0] instr_word,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic             instr_valid,
  output logic [WIDTH-1:0] ir,
  input  logic [1:0]       alu_op,
  input  logic [1:0]       alu_src2,
  input  logic [1:0]       wb_sel,
  input  logic             reg_we,
  input  logic             flags_we,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             use_imm,
  input  logic [1:0]       pc_sel,
  input  logic [3:0]       branch_cond,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             retired,
  output logic             busy,
  output logic             mem_err
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;

  state_t                  state;
  logic [WIDTH-1:0]        pc;
  logic [WIDTH-1:0]        imm;
  logic [WIDTH-1:0]        regs [2**REG_ADDR_W];
  logic                    z_f, c_f, s_f, v_f;
  logic [REG_ADDR_W-1:0]   rd_idx, rs_idx;
  logic signed [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0]        wb_val, pc_seq, pc_next;
  logic signed [WIDTH-1:0] alu_res_p1, wdata_p1;
  logic [3:0]              alu_flags_p1;
  logic [WIDTH-1:0]        rdata_p2;
  logic                    wb_block;

  // Returns {Z, C, S, V, result}; C is carry for add and borrow for sub.
  function automatic logic [WIDTH+3:0] alu_calc(input logic [1:0] op,
                                                input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    logic [WIDTH:0]        ur;
    logic signed [WIDTH:0] sr;
    logic [WIDTH-1:0]      r;
    logic                  c, v;
    ur = '0;
    sr = '0;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      2'b00: begin
        ur = {1'b0, a} + {1'b0, b};
        sr = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        r  = ur[WIDTH-1:0];
        c  = ur[WIDTH];
        v  = sr[WIDTH] ^ sr[WIDTH-1];
      end
      2'b01: begin
        ur = {1'b0, a} - {1'b0, b};
        sr = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        r  = ur[WIDTH-1:0];
        c  = ur[WIDTH];
        v  = sr[WIDTH] ^ sr[WIDTH-1];
      end
      2'b10:   r = a & b;
      default: r = a ^ b;
    endcase
    return {(r == '0), c, r[WIDTH-1], v, r};
  endfunction

  function automatic logic cond_met(input logic [3:0] cc, input logic z, c, s, v);
    case (cc)
      4'b0000: return 1'b1;
      4'b0001: return z;
      4'b0010: return c;
      4'b0011: return c | z;
      4'b0100: return !c & !z;
      4'b0101: return !c;
      4'b0110: return !z & (s == v);
      4'b0111: return s == v;
      4'b1000: return s != v;
      4'b1001: return z | (s != v);
      default: return 1'b0;
    endcase
  endfunction

  assign rd_idx     = ir[2*REG_ADDR_W-1:REG_ADDR_W];
  assign rs_idx     = ir[REG_ADDR_W-1:0];
  assign op_a       = regs[rd_idx];
  assign instr_addr = pc;
  assign dmem_addr  = alu_res_p1;
  assign dmem_wdata = wdata_p1;
  assign busy       = (state != FETCH);

  always_comb begin
    op_b = '0;
    case (alu_src2)
      2'b00:   op_b = regs[rs_idx];
      2'b01:   op_b = imm;
      2'b10:   op_b = WIDTH'(1);
      default: op_b = '0;
    endcase
  end

  always_comb begin
    wb_val = '0;
    case (wb_sel)
      2'b00:   wb_val = rdata_p2;
      2'b01:   wb_val = alu_res_p1;
      2'b10:   wb_val = regs[rs_idx];
      default: wb_val = imm;
    endcase
  end

  // Branch decisions use the flags as they stand before this WB updates them.
  always_comb begin
    pc_seq  = pc + WIDTH'(1) + WIDTH'(use_imm);
    pc_next = pc_seq;
    case (pc_sel)
      2'b01:   pc_next = cond_met(branch_cond, z_f, c_f, s_f, v_f) ? imm : pc_seq;
      2'b10:   pc_next = regs[rs_idx];
      2'b11:   pc_next = pc;
      default: pc_next = pc_seq;
    endcase
  end

`ifdef DATAPATH_MEM_TIMEOUT_EN
  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_p2;
  assign wb_block = tmo_p2;
`else
  assign wb_block = 1'b0;
  assign mem_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= '0;
      imm      <= '0;
      {z_f, c_f, s_f, v_f} <= 4'b0000;
      for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      retired  <= 1'b0;
`ifdef DATAPATH_MEM_TIMEOUT_EN
      mem_err  <= 1'b0;
      tmo_cnt  <= '0;
      tmo_p2   <= 1'b0;
`endif
    end else begin
      retired <= 1'b0;
      case (state)
        FETCH: if (instr_valid) begin
          ir    <= instr_word;
          imm   <= instr_imm;
          state <= EXEC;
        end
        // EXEC -> p1: ALU result, flags and store data registered
        EXEC: begin
          {alu_flags_p1, alu_res_p1} <= alu_calc(alu_op, op_a, op_b);
          wdata_p1 <= op_a;
`ifdef DATAPATH_MEM_TIMEOUT_EN
          tmo_cnt <= '0;
          tmo_p2  <= 1'b0;
`endif
          if (mem_rd || mem_wr) begin
            state    <= MEM;
            dmem_req <= 1'b1;
            dmem_we  <= mem_wr;
          end else begin
            state <= WB;
          end
        end
        // MEM -> p2: read data captured on ack
        MEM: begin
          if (dmem_ack) begin
            rdata_p2 <= dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= WB;
          end
`ifdef DATAPATH_MEM_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            tmo_p2   <= 1'b1;
            mem_err  <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= WB;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        WB: begin
          if (reg_we && !wb_block) regs[rd_idx] <= wb_val;
          if (flags_we) {z_f, c_f, s_f, v_f} <= alu_flags_p1;
          pc      <= pc_next;
          retired <= 1'b1;
          state   <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath; exercises the DATAPATH_MEM_TIMEOUT_EN path when that macro is defined.
module tb_multicycle_datapath;
  localparam int WIDTH = 16;
  localparam int RAW   = 5;
  localparam int TMO   = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] instr_addr, ir, dmem_addr, dmem_wdata;
  logic [WIDTH-1:0] instr_word = '0, instr_imm = '0, dmem_rdata = '0;
  logic             instr_valid = 1'b0, dmem_ack = 1'b0;
  logic [1:0]       alu_op = '0, alu_src2 = '0, wb_sel = '0, pc_sel = '0;
  logic             reg_we = 0, flags_we = 0, mem_rd = 0, mem_wr = 0, use_imm = 0;
  logic [3:0]       branch_cond = '0;
  logic             dmem_req, dmem_we, retired, busy, mem_err;

  int               checks = 0, errors = 0;
  int               n_cycles, req_cycles;
  logic [WIDTH-1:0] cap_addr, cap_wdata;
  logic             cap_we;
  logic             stray_ack = 1'b0;

  always #5 clk = ~clk;

  multicycle_datapath #(.WIDTH(WIDTH), .REG_ADDR_W(RAW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_word(instr_word),
    .instr_imm(instr_imm), .instr_valid(instr_valid), .ir(ir), .alu_op(alu_op),
    .alu_src2(alu_src2), .wb_sel(wb_sel), .reg_we(reg_we), .flags_we(flags_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .use_imm(use_imm), .pc_sel(pc_sel),
    .branch_cond(branch_cond), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .retired(retired), .busy(busy), .mem_err(mem_err)
  );

  function automatic logic [WIDTH-1:0] mk(input int rd, input int rs);
    return WIDTH'((rd << RAW) | rs);
  endfunction

  task automatic set_ctl(input logic [1:0] op, input logic [1:0] src2, input logic [1:0] wsel,
                         input logic rwe, input logic fwe, input logic mrd, input logic mwr,
                         input logic uimm, input logic [1:0] psel, input logic [3:0] cc);
    alu_op = op; alu_src2 = src2; wb_sel = wsel; reg_we = rwe; flags_we = fwe;
    mem_rd = mrd; mem_wr = mwr; use_imm = uimm; pc_sel = psel; branch_cond = cc;
  endtask

  // Issues one instruction from FETCH, answers memory after ack_delay wait cycles, returns on retired.
  task automatic exec_instr(input logic [WIDTH-1:0] word, input logic [WIDTH-1:0] immv,
                            input int ack_delay, input logic [WIDTH-1:0] rdata);
    bit done;
    @(negedge clk);
    instr_word = word; instr_imm = immv; instr_valid = 1'b1; dmem_ack = stray_ack;
    @(posedge clk);
    n_cycles = 1; req_cycles = 0; done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      if (retired) done = 1;
      else begin
        if (dmem_req) begin
          req_cycles++;
          if (req_cycles == 1) begin
            cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_we = dmem_we;
          end
          dmem_ack   = (req_cycles > ack_delay);
          dmem_rdata = rdata;
        end else dmem_ack = stray_ack;
        @(posedge clk);
        n_cycles++;
      end
    end
    dmem_ack = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL retire_bound: no retired within 600 cycles, ir=%h", ir); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (instr_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", instr_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (retired !== 1'b0) begin errors++; $display("FAIL reset_retired got %b want 0", retired); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dmem_req); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", mem_err); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h want 0000", ir); end
    rst = 1'b1;
  endtask

  task automatic test_add();
    set_ctl(2'b00, 2'b11, 2'b11, 1, 0, 0, 0, 0, 2'b00, 4'h0);
    exec_instr(mk(2, 0), 16'h0005, 0, '0);
    checks++; if (instr_addr !== 16'h0001) begin errors++; $display("FAIL ldi_pc got %h want 0001", instr_addr); end
    set_ctl(2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 0, 2'b00, 4'h0);
    exec_instr(mk(1, 2), '0, 0, '0);
    checks++; if (n_cycles !== 3) begin errors++; $display("FAIL add_latency got %0d want 3", n_cycles); end
    checks++; if (instr_addr !== 16'h0002) begin errors++; $display("FAIL add_pc got %h want 0002", instr_addr); end
    checks++; if (ir !== 16'h0022) begin errors++; $display("FAIL add_ir got %h want 0022", ir); end
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    exec_instr(mk(1, 0), '0, 0, '0);
    checks++; if (cap_wdata !== 16'h0005) begin errors++; $display("FAIL add_reg1 got %h want 0005", cap_wdata); end
    checks++; if (cap_addr !== 16'h0005) begin errors++; $display("FAIL store_addr got %h want 0005", cap_addr); end
    checks++; if (cap_we !== 1'b1) begin errors++; $display("FAIL store_we got %b want 1", cap_we); end
    checks++; if (n_cycles !== 4) begin errors++; $display("FAIL store_latency got %0d want 4", n_cycles); end
  endtask

  task automatic test_sub_branch();
    set_ctl(2'b01, 2'b10, 2'b01, 1, 1, 0, 0, 0, 2'b00, 4'h0);
    exec_instr(mk(3, 0), '0, 0, '0);
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 0, 1, 2'b01, 4'b0010);
    exec_instr('0, 16'h0040, 0, '0);
    checks++; if (instr_addr !== 16'h0040) begin errors++; $display("FAIL br_c got %h want 0040", instr_addr); end
    branch_cond = 4'b0001;
    exec_instr('0, 16'h0080, 0, '0);
    checks++; if (instr_addr !== 16'h0042) begin errors++; $display("FAIL br_z got %h want 0042", instr_addr); end
    branch_cond = 4'b0111;
    exec_instr('0, 16'h0080, 0, '0);
    checks++; if (instr_addr !== 16'h0044) begin errors++; $display("FAIL br_ge got %h want 0044", instr_addr); end
    branch_cond = 4'b1000;
    exec_instr('0, 16'h0100, 0, '0);
    checks++; if (instr_addr !== 16'h0100) begin errors++; $display("FAIL br_lt got %h want 0100", instr_addr); end
    branch_cond = 4'b0100;
    exec_instr('0, 16'h0200, 0, '0);
    checks++; if (instr_addr !== 16'h0102) begin errors++; $display("FAIL br_hi got %h want 0102", instr_addr); end
    branch_cond = 4'b1100;
    exec_instr('0, 16'h0200, 0, '0);
    checks++; if (instr_addr !== 16'h0104) begin errors++; $display("FAIL br_never got %h want 0104", instr_addr); end
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    exec_instr(mk(3, 0), '0, 0, '0);
    checks++; if (cap_wdata !== 16'hFFFF) begin errors++; $display("FAIL sub_result got %h want ffff", cap_wdata); end
    set_ctl(2'b11, 2'b00, 2'b01, 1, 1, 0, 0, 1, 2'b01, 4'b0001);
    exec_instr(mk(3, 3), 16'h0200, 0, '0);
    checks++; if (instr_addr !== 16'h0107) begin errors++; $display("FAIL br_oldflags got %h want 0107", instr_addr); end
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 0, 1, 2'b01, 4'b0001);
    exec_instr('0, 16'h0200, 0, '0);
    checks++; if (instr_addr !== 16'h0200) begin errors++; $display("FAIL br_newz got %h want 0200", instr_addr); end
    set_ctl(2'b00, 2'b11, 2'b11, 1, 0, 0, 0, 1, 2'b00, 4'h0);
    exec_instr(mk(4, 0), 16'h7FFF, 0, '0);
    set_ctl(2'b00, 2'b10, 2'b01, 1, 1, 0, 0, 0, 2'b00, 4'h0);
    exec_instr(mk(4, 0), '0, 0, '0);
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 0, 1, 2'b01, 4'b0111);
    exec_instr('0, 16'h0300, 0, '0);
    checks++; if (instr_addr !== 16'h0300) begin errors++; $display("FAIL br_ovf got %h want 0300", instr_addr); end
    branch_cond = 4'b0010;
    exec_instr('0, 16'h0400, 0, '0);
    checks++; if (instr_addr !== 16'h0302) begin errors++; $display("FAIL br_nocarry got %h want 0302", instr_addr); end
  endtask

  task automatic test_load();
    set_ctl(2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 1, 2'b00, 4'h0);
    exec_instr(mk(5, 0), 16'h0200, 4, 16'hBEEF);
    checks++; if (req_cycles !== 5) begin errors++; $display("FAIL load_req_len got %0d want 5", req_cycles); end
    checks++; if (n_cycles !== 8) begin errors++; $display("FAIL load_latency got %0d want 8", n_cycles); end
    checks++; if (cap_addr !== 16'h0200) begin errors++; $display("FAIL load_addr got %h want 0200", cap_addr); end
    checks++; if (cap_we !== 1'b0) begin errors++; $display("FAIL load_we got %b want 0", cap_we); end
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    exec_instr(mk(5, 0), '0, 0, '0);
    checks++; if (cap_wdata !== 16'hBEEF) begin errors++; $display("FAIL load_reg got %h want beef", cap_wdata); end
  endtask

  task automatic test_pc_wrap();
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 0, 1, 2'b01, 4'b0000);
    exec_instr('0, 16'hFFFF, 0, '0);
    checks++; if (instr_addr !== 16'hFFFF) begin errors++; $display("FAIL jmp_ffff got %h want ffff", instr_addr); end
    pc_sel = 2'b00;
    exec_instr('0, '0, 0, '0);
    checks++; if (instr_addr !== 16'h0001) begin errors++; $display("FAIL pc_wrap got %h want 0001", instr_addr); end
    use_imm = 1'b0; pc_sel = 2'b10;
    exec_instr(mk(0, 5), '0, 0, '0);
    checks++; if (instr_addr !== 16'hBEEF) begin errors++; $display("FAIL jmp_reg got %h want beef", instr_addr); end
    pc_sel = 2'b11;
    exec_instr('0, '0, 0, '0);
    checks++; if (instr_addr !== 16'hBEEF) begin errors++; $display("FAIL pc_hold got %h want beef", instr_addr); end
  endtask

  task automatic test_stray_ack();
    stray_ack = 1'b1;
    set_ctl(2'b00, 2'b01, 2'b01, 1, 0, 0, 0, 0, 2'b00, 4'h0);
    exec_instr(mk(7, 0), 16'h0003, 0, '0);
    checks++; if (n_cycles !== 3) begin errors++; $display("FAIL stray_nonmem got %0d want 3", n_cycles); end
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    exec_instr(mk(7, 0), '0, 2, '0);
    checks++; if (req_cycles !== 3) begin errors++; $display("FAIL stray_req_len got %0d want 3", req_cycles); end
    checks++; if (cap_wdata !== 16'h0003) begin errors++; $display("FAIL stray_wdata got %h want 0003", cap_wdata); end
    stray_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    int bad;
    set_ctl(2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 0, 2'b00, 4'h0);
    @(negedge clk); instr_word = mk(5, 0); instr_valid = 1'b1;
    @(posedge clk); @(negedge clk); instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_req_on got %b want 1", dmem_req); end
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk); rst = 1'b1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mid_req_off got %b want 0", dmem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_state got busy=%b want 0", busy); end
    checks++; if (instr_addr !== 16'h0000) begin errors++; $display("FAIL mid_pc got %h want 0000", instr_addr); end
    dmem_ack = 1'b1; dmem_rdata = 16'h1234; bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || retired !== 1'b0 || dmem_req !== 1'b0) bad++;
    end
    dmem_ack = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL late_ack got %0d active cycles want 0", bad); end
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    exec_instr(mk(5, 0), '0, 0, '0);
    checks++; if (cap_wdata !== 16'h0000) begin errors++; $display("FAIL reset_regs got %h want 0000", cap_wdata); end
  endtask

  task automatic test_mem_timeout();
    set_ctl(2'b00, 2'b11, 2'b11, 1, 0, 0, 0, 0, 2'b00, 4'h0);
    exec_instr(mk(6, 0), 16'h1234, 0, '0);
    set_ctl(2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 0, 2'b00, 4'h0);
`ifdef DATAPATH_MEM_TIMEOUT_EN
    exec_instr(mk(6, 0), '0, 100000, 16'h5555);
    checks++; if (n_cycles !== TMO + 3) begin errors++; $display("FAIL tmo_latency got %0d want %0d", n_cycles, TMO + 3); end
    checks++; if (req_cycles !== TMO) begin errors++; $display("FAIL tmo_req_len got %0d want %0d", req_cycles, TMO); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", mem_err); end
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    exec_instr(mk(6, 0), '0, 0, '0);
    checks++; if (cap_wdata !== 16'h1234) begin errors++; $display("FAIL tmo_reg got %h want 1234", cap_wdata); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", mem_err); end
`else
    exec_instr(mk(6, 0), '0, 300, 16'h5555);
    checks++; if (n_cycles !== 304) begin errors++; $display("FAIL long_wait got %0d want 304", n_cycles); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL no_tmo_err got %b want 0", mem_err); end
    set_ctl(2'b00, 2'b11, 2'b01, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    exec_instr(mk(6, 0), '0, 0, '0);
    checks++; if (cap_wdata !== 16'h5555) begin errors++; $display("FAIL long_reg got %h want 5555", cap_wdata); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_branch();
    test_load();
    test_pc_wrap();
    test_stray_ack();
    test_reset_mid_mem();
    test_mem_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
